// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the register file: default widths, address/word
// types and the hardwired zero register index.
package cpu_types_pkg;

  localparam int RF_DATA_W   = 32;
  localparam int RF_NREGS    = 32;
  localparam int RF_ADDR_W   = $clog2(RF_NREGS);
  localparam int RF_ZERO_REG = 0;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_DATA_W-1:0] word_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard for the register file.
// Per-register busy bits: set when an instruction that will write the
// register issues, cleared when the write lands, all cleared on squash.
// Update order within a cycle is flush, then writeback clears, then reserve,
// so a new producer reserved in the same cycle as an older writeback wins.
module rf_scoreboard
  import cpu_types_pkg::*;
#(
  parameter int NREGS  = 32,
  parameter int NWR    = 2,
  parameter int ADDR_W = $clog2(NREGS)
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [NWR-1:0]        wen,
  input  logic [NWR*ADDR_W-1:0] wsel,
  input  logic                  rsv_en,
  input  logic [ADDR_W-1:0]     rsv_sel,
  input  logic                  flush,
  output logic [NREGS-1:0]      busy_vec
);

  localparam logic [ADDR_W-1:0] ZERO_SEL = ADDR_W'(RF_ZERO_REG);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_next;

  // Next busy vector: flush, then writeback clears, then reserve sets.
  always_comb begin
    w_busy_next = flush ? '0 : r_busy;
    for (int w = 0; w < NWR; w++) begin
      if (wen[w]) begin
        w_busy_next[wsel[w*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end
    if (rsv_en && (rsv_sel != ZERO_SEL)) begin
      w_busy_next[rsv_sel] = 1'b1;
    end
    w_busy_next[RF_ZERO_REG] = 1'b0;
  end

  // Busy bit storage, dropped immediately on reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  assign busy_vec = r_busy;

endmodule

// File: rtl/multiport_register_file.sv
// Multiport general-purpose register file with pending-write scoreboard.
// NRD combinational read ports, NWR write ports (highest index wins on a
// same-register collision), register 0 hardwired to zero. Each read port
// reports whether its register still has a write outstanding.
// Optional macro RF_BYPASS_EN: forwards same-cycle write data to the read
// ports and suppresses rbusy for the forwarded register.
module multiport_register_file
  import cpu_types_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 2
) (
  input  logic                             CLK,
  input  logic                             nRST,
  input  logic [NRD*$clog2(NREGS)-1:0]     rsel,
  output logic [NRD*DATA_W-1:0]            rdat,
  output logic [NRD-1:0]                   rbusy,
  input  logic [NWR-1:0]                   wen,
  input  logic [NWR*$clog2(NREGS)-1:0]     wsel,
  input  logic [NWR*DATA_W-1:0]            wdat,
  input  logic                             rsv_en,
  input  logic [$clog2(NREGS)-1:0]         rsv_sel,
  input  logic                             flush,
  output logic [NREGS-1:0]                 busy_vec
);

  localparam int ADDR_W = $clog2(NREGS);
  localparam logic [ADDR_W-1:0] ZERO_SEL = ADDR_W'(RF_ZERO_REG);

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [NREGS-1:0]  w_busy;
  logic [NRD*DATA_W-1:0] w_rdat;
  logic [NRD-1:0]        w_rbusy;

  // Register storage; later write ports override earlier ones, reg 0 never written.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (wen[w] && (wsel[w*ADDR_W +: ADDR_W] != ZERO_SEL)) begin
          r_regs[wsel[w*ADDR_W +: ADDR_W]] <= wdat[w*DATA_W +: DATA_W];
        end
      end
    end
  end

  rf_scoreboard #(
    .NREGS  (NREGS),
    .NWR    (NWR),
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .CLK      (CLK),
    .nRST     (nRST),
    .wen      (wen),
    .wsel     (wsel),
    .rsv_en   (rsv_en),
    .rsv_sel  (rsv_sel),
    .flush    (flush),
    .busy_vec (w_busy)
  );

  // Read muxes with optional same-cycle forwarding from the write ports.
  always_comb begin
    logic [ADDR_W-1:0] sel;
    sel     = '0;
    w_rdat  = '0;
    w_rbusy = '0;
    for (int p = 0; p < NRD; p++) begin
      sel = rsel[p*ADDR_W +: ADDR_W];
      w_rdat[p*DATA_W +: DATA_W] = (sel == ZERO_SEL) ? '0 : r_regs[sel];
      w_rbusy[p] = w_busy[sel];
`ifdef RF_BYPASS_EN
      for (int w = 0; w < NWR; w++) begin
        if (nRST && wen[w] && (sel != ZERO_SEL) &&
            (wsel[w*ADDR_W +: ADDR_W] == sel)) begin
          w_rdat[p*DATA_W +: DATA_W] = wdat[w*DATA_W +: DATA_W];
          w_rbusy[p] = 1'b0;
        end
      end
`endif
    end
  end

  assign rdat     = w_rdat;
  assign rbusy    = w_rbusy;
  assign busy_vec = w_busy;

endmodule

// File: tb/tb_multiport_register_file.sv
// Directed bench for multiport_register_file (default 32x32, 2R2W).
// Inputs change just after the falling edge, outputs are sampled before
// the next falling edge, so the rising edge sits between drive and check.
module tb_multiport_register_file;

  localparam int DATA_W = 32;
  localparam int NREGS  = 32;
  localparam int NRD    = 2;
  localparam int NWR    = 2;
  localparam int ADDR_W = 5;

  logic                     CLK;
  logic                     nRST;
  logic [NRD*ADDR_W-1:0]    rsel;
  logic [NRD*DATA_W-1:0]    rdat;
  logic [NRD-1:0]           rbusy;
  logic [NWR-1:0]           wen;
  logic [NWR*ADDR_W-1:0]    wsel;
  logic [NWR*DATA_W-1:0]    wdat;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_sel;
  logic                     flush;
  logic [NREGS-1:0]         busy_vec;

  int checks   = 0;
  int failures = 0;

  multiport_register_file #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .NRD    (NRD),
    .NWR    (NWR)
  ) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .rsel     (rsel),
    .rdat     (rdat),
    .rbusy    (rbusy),
    .wen      (wen),
    .wsel     (wsel),
    .wdat     (wdat),
    .rsv_en   (rsv_en),
    .rsv_sel  (rsv_sel),
    .flush    (flush),
    .busy_vec (busy_vec)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // checking task
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic idle();
    wen     = '0;
    wsel    = '0;
    wdat    = '0;
    rsv_en  = 1'b0;
    rsv_sel = '0;
    flush   = 1'b0;
  endtask

  task automatic set_wr(input int port, input logic [ADDR_W-1:0] sel, input logic [DATA_W-1:0] dat);
    wen[port] = 1'b1;
    wsel[port*ADDR_W +: ADDR_W] = sel;
    wdat[port*DATA_W +: DATA_W] = dat;
  endtask

  task automatic set_rd(input logic [ADDR_W-1:0] s0, input logic [ADDR_W-1:0] s1);
    rsel[0 +: ADDR_W]      = s0;
    rsel[ADDR_W +: ADDR_W] = s1;
  endtask

  // advance across one rising edge, then return to idle inputs
  task automatic tick();
    @(negedge CLK);
    idle();
    #1;
  endtask

  logic [31:0] exp_busy;

  initial begin
    nRST = 1'b0;
    idle();
    set_rd(5'd0, 5'd0);
    #12;
    check("reset_busy_vec", busy_vec, 32'h0);
    set_rd(5'd5, 5'd31);
    #1;
    check("reset_rdat0", rdat[31:0], 32'h0);
    check("reset_rbusy", {30'b0, rbusy}, 32'h0);
    @(negedge CLK);
    nRST = 1'b1;

    // write r5, read back next cycle
    set_wr(0, 5'd5, 32'hDEADBEEF);
    tick();
    set_rd(5'd5, 5'd0);
    #1;
    check("r5_rdat", rdat[31:0], 32'hDEADBEEF);
    check("r5_rbusy", {31'b0, rbusy[0]}, 32'h0);
    check("r0_rdat", rdat[63:32], 32'h0);

    // writes and reserves of r0 are discarded
    set_wr(1, 5'd0, 32'hFFFFFFFF);
    rsv_en = 1'b1; rsv_sel = 5'd0;
    tick();
    set_rd(5'd0, 5'd5);
    #1;
    check("r0_after_write", rdat[31:0], 32'h0);
    check("r0_busy_vec", busy_vec, 32'h0);
    check("r5_unchanged", rdat[63:32], 32'hDEADBEEF);

    // both ports write r7, port 1 wins
    set_wr(0, 5'd7, 32'h11);
    set_wr(1, 5'd7, 32'h22);
    tick();
    set_rd(5'd7, 5'd7);
    #1;
    check("r7_priority_p0", rdat[31:0], 32'h22);
    check("r7_priority_p1", rdat[63:32], 32'h22);

    // reserve r3, then write it
    rsv_en = 1'b1; rsv_sel = 5'd3;
    tick();
    set_rd(5'd3, 5'd7);
    #1;
    check("r3_rbusy_reserved", {31'b0, rbusy[0]}, 32'h1);
    check("r3_busy_vec", busy_vec, 32'h8);
    check("r7_not_busy", {31'b0, rbusy[1]}, 32'h0);
    set_wr(0, 5'd3, 32'h55);
    #1;
`ifdef RF_BYPASS_EN
    check("r3_bypass_rdat", rdat[31:0], 32'h55);
    check("r3_bypass_rbusy", {31'b0, rbusy[0]}, 32'h0);
`else
    check("r3_write_cycle_rdat", rdat[31:0], 32'h0);
    check("r3_write_cycle_rbusy", {31'b0, rbusy[0]}, 32'h1);
`endif
    tick();
    #1;
    check("r3_after_write_rdat", rdat[31:0], 32'h55);
    check("r3_after_write_rbusy", {31'b0, rbusy[0]}, 32'h0);

    // reserve and write r4 in the same cycle -> stays pending
    rsv_en = 1'b1; rsv_sel = 5'd4;
    set_wr(1, 5'd4, 32'h44);
    tick();
    check("r4_rsv_and_write", busy_vec, 32'h10);
    // flush with reserve r9 -> only r9 pending
    rsv_en = 1'b1; rsv_sel = 5'd9;
    flush = 1'b1;
    tick();
    check("flush_with_rsv9", busy_vec, 32'h200);
    flush = 1'b1;
    tick();
    check("flush_only", busy_vec, 32'h0);

    // fill r1..r31 with their index, two per cycle
    for (int i = 1; i < NREGS; i += 2) begin
      set_wr(0, ADDR_W'(i), 32'(i));
      if (i + 1 < NREGS) set_wr(1, ADDR_W'(i + 1), 32'(i + 1));
      if (i == 29) begin
        rsv_en = 1'b1; rsv_sel = 5'd12;
      end
      tick();
    end
    for (int i = 1; i < NREGS; i++) begin
      set_rd(ADDR_W'(i), 5'd0);
      #1;
      check($sformatf("fill_r%0d", i), rdat[31:0], 32'(i));
    end
    exp_busy = 32'h1000;
    check("pre_reset_busy_vec", busy_vec, exp_busy);

    // async reset pulse in the middle of the low phase
    set_rd(5'd31, 5'd12);
    #1;
    nRST = 1'b0;
    #1;
    check("async_rst_r31", rdat[31:0], 32'h0);
    check("async_rst_rbusy12", {31'b0, rbusy[1]}, 32'h0);
    check("async_rst_busy_vec", busy_vec, 32'h0);
    for (int i = 1; i < NREGS; i += 5) begin
      set_rd(ADDR_W'(i), ADDR_W'(NREGS - i));
      #1;
      check($sformatf("rst_held_r%0d", i), rdat[31:0], 32'h0);
      check($sformatf("rst_held_r%0d", NREGS - i), rdat[63:32], 32'h0);
    end
    @(negedge CLK);
    nRST = 1'b1;
    tick();
    set_rd(5'd12, 5'd1);
    #1;
    check("post_reset_r1", rdat[63:32], 32'h0);
    check("post_reset_busy_vec", busy_vec, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
